// File: rtl/cpu_run_controller.sv
// Run/step/breakpoint sequencer generating the enable strobe for the 8-bit cpu core.
// Define CPU_RUN_CTRL_BREAKPOINT_EN to build the breakpoint logic and the BREAK state.
module cpu_run_controller #(
  parameter int unsigned SLOW_DIV  = 12500000,
  parameter int unsigned DIV_WIDTH = 24
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        run_btn,
  input  logic        step_btn,
  input  logic        turbo,
  input  logic [7:0]  instruction_pointer,
  input  logic [7:0]  bp_addr,
  input  logic        bp_valid,
  output logic        cpu_enable,
  output logic [1:0]  state,
  output logic        bp_hit,
  output logic [15:0] cycle_count
);

  typedef enum logic [1:0] {
    S_HALT  = 2'b00,
    S_RUN   = 2'b01,
    S_STEP  = 2'b10,
    S_BREAK = 2'b11
  } state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(SLOW_DIV - 1);

  state_t               state_q, state_d;
  logic                 run_prev_q, run_prev_d;
  logic                 step_prev_q, step_prev_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [15:0]          cnt_q, cnt_d;

  logic run_edge, step_edge, tick, bp_match, enable_c;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_HALT;
      run_prev_q  <= 1'b0;
      step_prev_q <= 1'b0;
      div_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      run_prev_q  <= run_prev_d;
      step_prev_q <= step_prev_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
    end
  end

  // A run edge suppresses a coincident step edge.
  always_comb begin
    run_prev_d  = run_btn;
    step_prev_d = step_btn;
    run_edge    = run_btn & ~run_prev_q;
    step_edge   = step_btn & ~step_prev_q & ~run_edge;
    tick        = (div_q == DIV_LAST);
    enable_c    = (state_q == S_STEP) |
                  ((state_q == S_RUN) & (turbo | tick) & ~bp_match & ~run_edge);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HALT: begin
        if (run_edge)       state_d = S_RUN;
        else if (step_edge) state_d = S_STEP;
      end
      S_RUN: begin
        if (run_edge)      state_d = S_HALT;
        else if (bp_match) state_d = S_BREAK;
      end
      S_STEP: state_d = S_HALT;
      S_BREAK: begin
        if (run_edge)       state_d = S_RUN;
        else if (step_edge) state_d = S_STEP;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_comb begin
    div_d = '0;
    if (state_q == S_RUN && !turbo) begin
      div_d = tick ? '0 : div_q + 1'b1;
    end
    cnt_d = cnt_q;
    if (enable_c && cnt_q != '1) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  logic skip_q, skip_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) skip_q <= 1'b0;
    else         skip_q <= skip_d;
  end

  // skip masks the breakpoint we just halted on until one instruction has run.
  always_comb begin
    skip_d = skip_q;
    if (state_q == S_BREAK && run_edge) begin
      skip_d = 1'b1;
    end
    if (state_q == S_RUN && (enable_c || state_d != S_RUN)) begin
      skip_d = 1'b0;
    end
  end

  assign bp_match = bp_valid & (instruction_pointer == bp_addr) & ~skip_q;
  assign bp_hit   = (state_q == S_BREAK);
`else
  logic unused_bp;
  assign unused_bp = ^{bp_addr, bp_valid, instruction_pointer};
  assign bp_match  = 1'b0;
  assign bp_hit    = 1'b0;
`endif

  assign cpu_enable  = enable_c;
  assign state       = state_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Self-checking bench for cpu_run_controller: vector table plus hand-written corner sequences.
module tb_cpu_run_controller;

  localparam int unsigned SLOW_DIV = 4;
  localparam logic [1:0] H = 2'b00, R = 2'b01, S = 2'b10, B = 2'b11;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        run_btn = 1'b0, step_btn = 1'b0, turbo = 1'b0, bp_valid = 1'b0;
  logic [7:0]  ip;
  logic [7:0]  bp_addr = 8'h00;
  logic        cpu_enable, bp_hit;
  logic [1:0]  state;
  logic [15:0] cycle_count;

  int total = 0;
  int bad = 0;
  logic [15:0] mdl_cnt = 16'd0;

  cpu_run_controller #(.SLOW_DIV(SLOW_DIV), .DIV_WIDTH(3)) dut (
    .clk(clk), .resetn(resetn), .run_btn(run_btn), .step_btn(step_btn), .turbo(turbo),
    .instruction_pointer(ip), .bp_addr(bp_addr), .bp_valid(bp_valid),
    .cpu_enable(cpu_enable), .state(state), .bp_hit(bp_hit), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Minimal cpu model: IP advances on every enabled cycle.
  always @(posedge clk or negedge resetn) begin
    if (!resetn)         ip <= 8'd0;
    else if (cpu_enable) ip <= ip + 8'd1;
  end

  typedef struct { logic en; logic [1:0] st; logic hit; logic [15:0] cnt; } exp_t;
  typedef struct { logic run; logic step; logic turbo; logic en; logic [1:0] st; } vec_t;
  exp_t sb[$];
  vec_t tbl[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after a rising edge; drives inputs, checks the cycle at the falling edge.
  task automatic cyc(input string name, input logic r, input logic s, input logic t,
                     input logic e_en, input logic [1:0] e_st, input logic e_hit);
    exp_t x;
    run_btn = r; step_btn = s; turbo = t;
    x.en = e_en; x.st = e_st; x.hit = e_hit; x.cnt = mdl_cnt;
    sb.push_back(x);
    @(negedge clk);
    x = sb.pop_front();
    check({name, ".en"},  16'(cpu_enable), 16'(x.en));
    check({name, ".st"},  16'(state),      16'(x.st));
    check({name, ".hit"}, 16'(bp_hit),     16'(x.hit));
    check({name, ".cnt"}, cycle_count,     x.cnt);
    if (x.en && mdl_cnt != 16'hFFFF) mdl_cnt = mdl_cnt + 16'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic s, input logic t, input logic e, input logic [1:0] st);
    vec_t v;
    v.run = r; v.step = s; v.turbo = t; v.en = e; v.st = st;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    #2 resetn = 1'b0;
    run_btn = 1'b0; step_btn = 1'b0;
    #1;
    mdl_cnt = 16'd0;
    @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  initial begin
    // Turbo run for 10 cycles then stop.
    add(1, 0, 1, 0, H);
    for (int i = 0; i < 10; i++) add(0, 0, 1, 1, R);
    add(1, 0, 1, 0, R);
    add(0, 0, 1, 0, H);
    // Slow run: enable every SLOW_DIV cycles, stop edge lands on a tick.
    add(1, 0, 0, 0, H);
    for (int i = 0; i < 11; i++) add(0, 0, 0, ((i % 4) == 3), R);
    add(1, 0, 0, 0, R);
    add(0, 0, 0, 0, H);
    // Step button held for five cycles.
    add(0, 1, 0, 0, H);
    add(0, 1, 0, 1, S);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, H);
    add(0, 0, 0, 0, H);
    // Coincident run and step edges.
    add(1, 1, 1, 0, H);
    add(0, 0, 1, 1, R);
    add(0, 0, 1, 1, R);

    #12;
    check("reset.en",  16'(cpu_enable), 16'd0);
    check("reset.st",  16'(state),      16'(H));
    check("reset.hit", 16'(bp_hit),     16'd0);
    check("reset.cnt", cycle_count,     16'd0);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      cyc($sformatf("vec%0d", i), tbl[i].run, tbl[i].step, tbl[i].turbo, tbl[i].en, tbl[i].st, 1'b0);
    end

    // Reset asserted mid-RUN takes effect without waiting for a clock.
    #2 resetn = 1'b0;
    #1;
    check("midrst.en",  16'(cpu_enable), 16'd0);
    check("midrst.st",  16'(state),      16'(H));
    check("midrst.hit", 16'(bp_hit),     16'd0);
    check("midrst.cnt", cycle_count,     16'd0);
    mdl_cnt = 16'd0;
    @(posedge clk);
    #1;
    check("midrst.hold.en", 16'(cpu_enable), 16'd0);
    run_btn = 1'b0; step_btn = 1'b0;
    resetn = 1'b1;

    // Breakpoint at IP 5, then resume past it.
    bp_valid = 1'b1; bp_addr = 8'h05;
    cyc("bp.go", 1, 0, 1, 0, H, 0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp.ip%0d", i), 16'(ip), 16'(i));
      cyc($sformatf("bp.run%0d", i), 0, 0, 1, 1, R, 0);
    end
    check("bp.ip5", 16'(ip), 16'd5);
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    cyc("bp.match", 0, 0, 1, 0, R, 0);
    cyc("bp.brk0",  0, 0, 1, 0, B, 1);
    cyc("bp.brk1",  0, 0, 1, 0, B, 1);
    check("bp.hold.ip", 16'(ip), 16'd5);
    cyc("bp.resume", 1, 0, 1, 0, B, 1);
    cyc("bp.skip",   0, 0, 1, 1, R, 0);
    check("bp.ip6", 16'(ip), 16'd6);
    cyc("bp.after",  0, 0, 1, 1, R, 0);
`else
    cyc("nobp.ip5", 0, 0, 1, 1, R, 0);
    cyc("nobp.ip6", 0, 0, 1, 1, R, 0);
    check("nobp.ip7", 16'(ip), 16'd7);
`endif
    cyc("bp.stop", 1, 0, 1, 0, R, 0);
    cyc("bp.idle", 0, 0, 1, 0, H, 0);
    bp_valid = 1'b0;

    // Saturation of the enable counter.
    do_reset();
    turbo = 1'b1;
    run_btn = 1'b1;
    @(posedge clk);
    #1 run_btn = 1'b0;
    repeat (65534) @(posedge clk);
    #1;
    check("sat.fffe", cycle_count, 16'hFFFE);
    repeat (6) @(posedge clk);
    #1;
    check("sat.ffff", cycle_count, 16'hFFFF);
    check("sat.en",   16'(cpu_enable), 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
